// File: rtl/dccm_pkg.sv
// Shared constants and types for the DCCM two-master bus front end.
// Holds the window geometry, the master IDs and the response-stage record.
package dccm_pkg;

    localparam logic [31:0] DCCM_ADDR_BASE = 32'h0010_0000;
    localparam int          DCCM_MEM_WORDS = 32768;

    localparam logic MST_CORE = 1'b0;
    localparam logic MST_DBG  = 1'b1;

    // One-deep response record, loaded on every grant.
    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
        logic rd_hit;
    } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a combinational one-hot grant.
// The last-grant flop resets to the debug port so the core port wins the first tie.
module rr_arb2
    import dccm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[0] && (!req[1] || last_gnt == MST_DBG)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= MST_DBG;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/dccm_bus_arbiter.sv
// Arbitrates the core LSU and debug/loader ports onto the DCCM SRAM bus,
// range-checks the address and returns a fixed one-cycle response to the granted master.
module dccm_bus_arbiter
    import dccm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = DCCM_ADDR_BASE,
    parameter int          MEM_WORDS = DCCM_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS) << 2;

    // Handshake: a master holds req and its fields until gnt is high in the same
    // cycle; the transfer happens on that edge and rvalid follows exactly one cycle later.
    logic [1:0]  gnt;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic [31:0] offset;
    logic        hit;
    rsp_t        rsp;
    logic        rsp_live;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_req_i, m0_req_i}),
        .gnt (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign any_gnt  = |gnt;

    always_comb begin
        sel_addr  = m0_addr_i;
        sel_we    = m0_we_i;
        sel_be    = m0_be_i;
        sel_wdata = m0_wdata_i;
        if (gnt[1]) begin
            sel_addr  = m1_addr_i;
            sel_we    = m1_we_i;
            sel_be    = m1_be_i;
            sel_wdata = m1_wdata_i;
        end
    end

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign offset = sel_addr - ADDR_BASE;
    assign hit    = offset < WIN_BYTES;

    assign data_req_o   = any_gnt & hit;
    assign data_addr_o  = data_req_o ? (offset & ~32'h3) : 32'h0;
    assign data_we_o    = data_req_o & sel_we;
    assign data_be_o    = data_req_o ? sel_be : 4'h0;
    assign data_wdata_o = data_req_o ? sel_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp <= '0;
        end else begin
            rsp <= '{valid:  any_gnt,
                     owner:  gnt[1],
                     err:    any_gnt & ~hit,
                     rd_hit: any_gnt & hit & ~sel_we};
        end
    end

    // A response still held while reset is asserted must never reach a master.
    assign rsp_live = rsp.valid & ~rst;

    assign m0_rvalid_o = rsp_live & (rsp.owner == MST_CORE);
    assign m1_rvalid_o = rsp_live & (rsp.owner == MST_DBG);
    assign m0_rdata_o  = (m0_rvalid_o & rsp.rd_hit) ? data_rdata_i : 32'h0;
    assign m1_rdata_o  = (m1_rvalid_o & rsp.rd_hit) ? data_rdata_i : 32'h0;
    assign m0_err_o    = m0_rvalid_o & rsp.err;
    assign m1_err_o    = m1_rvalid_o & rsp.err;

endmodule
